// File: rtl/video_timing_gen.sv
// Raster timing generator: scans cx/cy on clk_pixel and realigns returned rgb with de/hsync/vsync.
// Optional macro VTG_TEST_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
module video_timing_gen #(
    parameter int FRAME_WIDTH   = 2200,
    parameter int FRAME_HEIGHT  = 1125,
    parameter int SCREEN_WIDTH  = 1920,
    parameter int SCREEN_HEIGHT = 1080,
    parameter int H_FRONT       = 88,
    parameter int H_SYNC        = 44,
    parameter int V_FRONT       = 4,
    parameter int V_SYNC        = 5,
    parameter int HSYNC_POL     = 1,
    parameter int VSYNC_POL     = 1,
    parameter int BIT_WIDTH     = 12,
    parameter int BIT_HEIGHT    = 11,
    parameter int RGB_LATENCY   = 1
) (
    input  logic                  clk_pixel,
    input  logic                  clk_pixel_resetn,
    input  logic                  enable,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  running,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [31:0]           frame_count,
    input  logic [23:0]           rgb_in,
`ifdef VTG_TEST_PATTERN_EN
    input  logic                  pattern_sel,
`endif
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic [23:0]           rgb_out
);

    generate
        if (SCREEN_WIDTH + H_FRONT + H_SYNC > FRAME_WIDTH) begin : g_err_h
            $error("video_timing_gen: horizontal active+porch+sync exceeds FRAME_WIDTH");
        end
        if (SCREEN_HEIGHT + V_FRONT + V_SYNC > FRAME_HEIGHT) begin : g_err_v
            $error("video_timing_gen: vertical active+porch+sync exceeds FRAME_HEIGHT");
        end
        if (FRAME_WIDTH > 2**BIT_WIDTH) begin : g_err_bw
            $error("video_timing_gen: BIT_WIDTH too narrow for FRAME_WIDTH");
        end
        if (FRAME_HEIGHT > 2**BIT_HEIGHT) begin : g_err_bh
            $error("video_timing_gen: BIT_HEIGHT too narrow for FRAME_HEIGHT");
        end
        if (RGB_LATENCY < 1) begin : g_err_lat
            $error("video_timing_gen: RGB_LATENCY must be at least 1");
        end
    endgenerate

    localparam logic [BIT_WIDTH-1:0]  CX_LAST  = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0]  CX_ONE   = BIT_WIDTH'(1);
    localparam logic [BIT_HEIGHT-1:0] CY_LAST  = BIT_HEIGHT'(FRAME_HEIGHT - 1);
    localparam logic [BIT_HEIGHT-1:0] CY_ONE   = BIT_HEIGHT'(1);
    localparam int                    HS_START = SCREEN_WIDTH + H_FRONT;
    localparam int                    HS_END   = HS_START + H_SYNC;
    localparam int                    VS_START = SCREEN_HEIGHT + V_FRONT;
    localparam int                    VS_END   = VS_START + V_SYNC;
    localparam logic                  HS_HIGH  = (HSYNC_POL != 0);
    localparam logic                  VS_HIGH  = (VSYNC_POL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [BIT_WIDTH-1:0]    cx_n;
    logic [BIT_HEIGHT-1:0]   cy_n;
    logic                    run_n;
    logic                    frame_wrap;
    logic                    de_r;
    logic                    hs_r;
    logic                    vs_r;
    logic [RGB_LATENCY:0]    de_pipe;
    logic [RGB_LATENCY:0]    hs_pipe;
    logic [RGB_LATENCY:0]    vs_pipe;
    logic [23:0]             pixel;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        cx_n       = cx;
        cy_n       = cy;
        frame_wrap = (cx == CX_LAST) && (cy == CY_LAST);
        case (state)
            IDLE: begin
                cx_n = '0;
                cy_n = '0;
                if (enable) state_n = RUN;
            end
            RUN, DRAIN: begin
                // A stop request only takes effect once the frame in flight has been scanned out.
                if (enable)
                    state_n = RUN;
                else if (state == DRAIN && frame_wrap)
                    state_n = IDLE;
                else
                    state_n = DRAIN;

                if (cx == CX_LAST) begin
                    cx_n = '0;
                    cy_n = (cy == CY_LAST) ? '0 : cy + CY_ONE;
                end else begin
                    cx_n = cx + CX_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cx_n    = '0;
                cy_n    = '0;
            end
        endcase
        run_n = (state_n != IDLE);
    end

    always_comb begin
        de_r = running && (int'(cx) < SCREEN_WIDTH) && (int'(cy) < SCREEN_HEIGHT);
        hs_r = running && (int'(cx) >= HS_START) && (int'(cx) < HS_END);
        vs_r = running && (int'(cy) >= VS_START) && (int'(cy) < VS_END);
    end

`ifdef VTG_TEST_PATTERN_EN
    localparam int BAR_W = (SCREEN_WIDTH >= 8) ? SCREEN_WIDTH / 8 : 1;

    logic [BIT_WIDTH-1:0] cx_pipe [RGB_LATENCY];
    logic [23:0]          bar_rgb;

    // NOTE: the cx delay line is left unreset; its contents are only looked at while de is high,
    // and by then it has been filled with valid coordinates.
    always_ff @(posedge clk_pixel) begin
        cx_pipe[0] <= cx;
        for (int i = 1; i < RGB_LATENCY; i++) cx_pipe[i] <= cx_pipe[i-1];
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (int'(cx_pipe[RGB_LATENCY-1]) / BAR_W)
            0:       bar_rgb = 24'hFFFFFF;
            1:       bar_rgb = 24'hFFFF00;
            2:       bar_rgb = 24'h00FFFF;
            3:       bar_rgb = 24'h00FF00;
            4:       bar_rgb = 24'hFF00FF;
            5:       bar_rgb = 24'hFF0000;
            6:       bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign pixel = pattern_sel ? bar_rgb : rgb_in;
`else
    assign pixel = rgb_in;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
        if (!clk_pixel_resetn) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            running     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            de_pipe     <= '0;
            hs_pipe     <= '0;
            vs_pipe     <= '0;
            rgb_out     <= '0;
        end else begin
            state       <= state_n;
            cx          <= cx_n;
            cy          <= cy_n;
            running     <= run_n;
            line_start  <= run_n && (cx_n == '0);
            frame_start <= run_n && (cx_n == '0) && (cy_n == '0);
            if (frame_start) frame_count <= frame_count + 32'd1;
            de_pipe     <= {de_pipe[RGB_LATENCY-1:0], de_r};
            hs_pipe     <= {hs_pipe[RGB_LATENCY-1:0], hs_r};
            vs_pipe     <= {vs_pipe[RGB_LATENCY-1:0], vs_r};
            // rgb_out lines up with the de that is one shift away from the output stage.
            rgb_out     <= de_pipe[RGB_LATENCY-1] ? pixel : 24'h000000;
        end
    end

    assign de    = de_pipe[RGB_LATENCY];
    assign hsync = hs_pipe[RGB_LATENCY] ^ ~HS_HIGH;
    assign vsync = vs_pipe[RGB_LATENCY] ^ ~VS_HIGH;

endmodule
